// File: rtl/serial_frame_pkg.sv
// Shared types and width helpers for the serial frame transmitter.
package serial_frame_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Producer-side word handshake into the serial frame transmitter.
interface serial_frame_tx_if
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc,
  output logic o_tc_next_c
);

  localparam int unsigned      CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tc;

  // Next count: clear wins, otherwise advance and wrap on terminal count.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = r_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tc_next_c = (w_cnt_next == LAST);
  assign o_tc        = r_tc;

  // Count register with terminal-count flag kept alongside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_tc  <= (LAST == '0);
    end else begin
      r_cnt <= w_cnt_next;
      r_tc  <= o_tc_next_c;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start, data LSB first, optional parity, stop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_tx_if.slave   s_if,
  output logic               tx_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic                r_parity;
  logic                r_tx_out;
  logic                r_busy;
  logic                r_done;
  logic                r_tx_ready;
  logic                w_accept;
  logic                w_tc;
  logic                w_tc_next;
  logic                w_tx_out_next;
  logic                w_done_next;

  // Timer runs only while a frame is in flight; held at zero in IDLE.
  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_clr       (r_state == IDLE),
    .i_en        (r_state != IDLE),
    .o_tc        (w_tc),
    .o_tc_next_c (w_tc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, shift/index update and next-cycle output values.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_idx_next    = r_idx;
    w_accept      = 1'b0;
    w_tx_out_next = 1'b1;
    w_done_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (s_if.tx_valid) begin
          w_accept     = 1'b1;
          w_shift_next = s_if.tx_data;
          w_idx_next   = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_tc) w_state_next = DATA;
      end
      DATA: begin
        if (w_tc) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            w_idx_next   = '0;
            w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_tc) w_state_next = STOP;
      end
      STOP: begin
        if (w_tc) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    case (w_state_next)
      START:   w_tx_out_next = 1'b0;
      DATA:    w_tx_out_next = w_shift_next[0];
      PARITY:  w_tx_out_next = r_parity;
      default: w_tx_out_next = 1'b1;
    endcase

    // Next cycle is the final clock of the stop bit.
    w_done_next = (w_state_next == STOP) && w_tc_next;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_shift    <= w_shift_next;
      r_idx      <= w_idx_next;
      if (w_accept) r_parity <= (^s_if.tx_data) ^ (PARITY_ODD != 0);
      r_tx_out   <= w_tx_out_next;
      r_busy     <= (w_state_next != IDLE);
      r_done     <= w_done_next;
      r_tx_ready <= (w_state_next == IDLE);
    end
  end

  assign s_if.tx_ready = r_tx_ready;
  assign tx_out        = r_tx_out;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx across four parameter sets.
module tb_serial_frame_tx;

  // Instance 0: even parity CPB4, 1: odd parity, 2: no parity, 3: CPB1 even parity.
  localparam logic [3:0] PEN  = 4'b1011;
  localparam logic [3:0] PODD = 4'b0010;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tb_data [4];
  logic [3:0] tb_valid;
  logic [3:0] tx_out, busy, done, rdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_line, exp_bsy, exp_dn, mask;
  logic [127:0] got_line, got_bsy, got_dn, got_rdy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_frame_tx_if #(.DATA_W(8)) bus ();
    assign bus.tx_data  = tb_data[g];
    assign bus.tx_valid = tb_valid[g];
    assign rdy[g]       = bus.tx_ready;

    serial_frame_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT ((g == 3) ? 1 : 4),
      .PARITY_EN    (32'(PEN[g])),
      .PARITY_ODD   (32'(PODD[g]))
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .s_if   (bus),
      .tx_out (tx_out[g]),
      .busy   (busy[g]),
      .done   (done[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_init(input int ncyc);
    mask = '0;
    for (int i = 0; i < ncyc; i++) mask[i] = 1'b1;
    exp_line = mask;
    exp_bsy  = '0;
    exp_dn   = '0;
  endtask

  // bits[b] is the b-th transmitted bit; the frame starts at cycle index off.
  task automatic exp_frame(input logic [15:0] bits, input int nb, input int cpb, input int off);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        exp_line[off + b*cpb + c] = bits[b];
        exp_bsy[off + b*cpb + c]  = 1'b1;
      end
    end
    exp_dn[off + nb*cpb - 1] = 1'b1;
  endtask

  // Offer a word on instance k, then sample ncyc cycles after the accepting edge.
  task automatic capture(input int k, input logic [7:0] d, input int ncyc,
                         input int chg_cyc, input logic [7:0] chg_d, input int drop_cyc);
    @(negedge clk);
    chk("ready_before_send", 128'(rdy[k]), 128'd1);
    tb_data[k]  = d;
    tb_valid[k] = 1'b1;
    got_line = '0; got_bsy = '0; got_dn = '0; got_rdy = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      got_line[i] = tx_out[k];
      got_bsy[i]  = busy[k];
      got_dn[i]   = done[k];
      got_rdy[i]  = rdy[k];
      if (i + 1 == chg_cyc)  tb_data[k]  = chg_d;
      if (i + 1 == drop_cyc) tb_valid[k] = 1'b0;
    end
  endtask

  task automatic check_capture(input string pfx);
    chk({pfx, "_tx_out"}, got_line, exp_line);
    chk({pfx, "_busy"},   got_bsy,  exp_bsy);
    chk({pfx, "_done"},   got_dn,   exp_dn);
    chk({pfx, "_ready"},  got_rdy,  mask & ~exp_bsy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc_done, acc_busy;

    // Reset held two clocks with valid asserted everywhere.
    rst = 1'b0;
    tb_valid = 4'hF;
    for (int i = 0; i < 4; i++) tb_data[i] = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_out", 128'(tx_out), 128'hF);
    chk("rst_ready",  128'(rdy),    128'hF);
    chk("rst_busy",   128'(busy),   128'h0);
    chk("rst_done",   128'(done),   128'h0);
    tb_valid = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 128'({busy, tx_out}), 128'h0F);

    // 0xA5, even parity, 4 clocks per bit.
    capture(0, 8'hA5, 45, 0, 8'h00, 1);
    exp_init(45);
    exp_frame(16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4, 0);
    check_capture("a5_even");

    // 0x07, odd parity: three ones give parity 0.
    capture(1, 8'h07, 45, 0, 8'h00, 1);
    exp_init(45);
    exp_frame(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 4, 0);
    check_capture("07_odd");

    // 0x07, no parity slot: 40-clock frame.
    capture(2, 8'h07, 41, 0, 8'h00, 1);
    exp_init(41);
    exp_frame(16'({1'b1, 8'h07, 1'b0}), 10, 4, 0);
    check_capture("07_nopar");

    // Back-to-back: valid held, data switched to 0xC3 during frame 1.
    capture(0, 8'h3C, 90, 10, 8'hC3, 50);
    exp_init(90);
    exp_frame(16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 4, 0);
    exp_frame(16'({1'b1, 1'b0, 8'hC3, 1'b0}), 11, 4, 45);
    check_capture("b2b");

    // Reset at clock 20 of a frame.
    @(negedge clk);
    tb_data[0]  = 8'hA5;
    tb_valid[0] = 1'b1;
    @(negedge clk);
    tb_valid[0] = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", 128'(busy[0]), 128'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_line", 128'({tx_out[0], busy[0], rdy[0]}), 128'b101);
    rst = 1'b1;
    acc_done = 1'b0;
    acc_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc_done |= done[0];
      acc_busy |= busy[0];
    end
    chk("abort_no_done", 128'({acc_done, acc_busy}), 128'd0);
    capture(0, 8'h5A, 45, 0, 8'h00, 1);
    exp_init(45);
    exp_frame(16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 4, 0);
    check_capture("after_abort");

    // One clock per bit, 0xFF: eight ones give even parity 0.
    capture(3, 8'hFF, 12, 0, 8'h00, 1);
    exp_init(12);
    exp_frame(16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 1, 0);
    check_capture("ff_cpb1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
